lpm_dffpipe_elastic: RTL

- Parametrised successor to the fixed-delay FIFO synchroniser pipe.
- An lpm_delay-stage register pipeline carrying data plus a per-stage valid bit, with valid/ready backpressure and bubble collapsing: a stalled output does not stall empty upstream stages.
- Used between dual-clock FIFO pointer/data paths and downstream consumers that can stall; lpm_delay=0 degenerates to a wire.

---
 rtl/lpm_dffpipe_elastic_if.sv | 23 ++
 rtl/lpm_dffpipe_elastic.sv | 85 ++++++++
 2 files changed

// File: rtl/lpm_dffpipe_elastic_if.sv
// rtl/lpm_dffpipe_elastic_if.sv - producer/consumer handshake bundle for the elastic pipe
interface lpm_dffpipe_elastic_if #(
    parameter int lpm_width    = 8,
    parameter int lpm_cntwidth = 2
);
    logic [lpm_width-1:0]    d;
    logic                    d_valid;
    logic                    d_ready;
    logic [lpm_width-1:0]    q;
    logic                    q_valid;
    logic                    q_ready;
    logic [lpm_cntwidth-1:0] usedw;

    modport master (
        output d, d_valid, q_ready,
        input  d_ready, q, q_valid, usedw
    );

    modport slave (
        input  d, d_valid, q_ready,
        output d_ready, q, q_valid, usedw
    );
endinterface

// File: rtl/lpm_dffpipe_elastic.sv
// rtl/lpm_dffpipe_elastic.sv - register pipe with per-stage valid, backpressure and bubble collapse
module lpm_dffpipe_elastic #(
    parameter int lpm_width    = 8,
    parameter int lpm_delay    = 3,
    parameter int lpm_cntwidth = 2
) (
    input  logic                  clock,
    input  logic                  sclr,
    lpm_dffpipe_elastic_if.slave  bus
);

    if (lpm_delay == 0) begin : g_wire
        logic unused_ok;
        assign unused_ok   = clock ^ sclr;
        assign bus.q       = bus.d;
        assign bus.q_valid = bus.d_valid;
        assign bus.d_ready = bus.q_ready;
        assign bus.usedw   = '0;
    end else begin : g_pipe
        localparam int top = lpm_delay - 1;

        logic [lpm_width-1:0]    data_r   [lpm_delay];
        logic [lpm_width-1:0]    up_data  [lpm_delay];
        logic [lpm_delay-1:0]    valid_r;
        logic [lpm_delay-1:0]    up_valid;
        logic [lpm_delay-1:0]    rdy;
        logic [lpm_cntwidth-1:0] usedw_r;
        logic                    in_xfer;
        logic                    out_xfer;

        // Readiness ripples from the output back: an empty stage is always free,
        // which is what lets a new word slide up behind a stalled one.
        always_comb begin
            logic chain;
            rdy      = '0;
            chain    = !valid_r[top] || bus.q_ready;
            rdy[top] = chain;
            for (int i = top - 1; i >= 0; i--) begin
                chain  = !valid_r[i] || chain;
                rdy[i] = chain;
            end
        end

        always_comb begin
            up_valid    = '0;
            up_valid[0] = bus.d_valid;
            up_data[0]  = bus.d;
            for (int i = 1; i < lpm_delay; i++) begin
                up_valid[i] = valid_r[i-1];
                up_data[i]  = data_r[i-1];
            end
        end

        assign in_xfer  = bus.d_valid && rdy[0];
        assign out_xfer = valid_r[top] && bus.q_ready;

        // Data only loads under a valid upstream word, so q keeps its last
        // value while bubbles pass through.
        always_ff @(posedge clock) begin
            if (sclr) begin
                valid_r <= '0;
                usedw_r <= '0;
                for (int i = 0; i < lpm_delay; i++) begin
                    data_r[i] <= '0;
                end
            end else begin
                for (int i = 0; i < lpm_delay; i++) begin
                    if (rdy[i]) begin
                        valid_r[i] <= up_valid[i];
                        if (up_valid[i]) begin
                            data_r[i] <= up_data[i];
                        end
                    end
                end
                usedw_r <= usedw_r + lpm_cntwidth'(in_xfer) - lpm_cntwidth'(out_xfer);
            end
        end

        assign bus.d_ready = rdy[0];
        assign bus.q       = data_r[top];
        assign bus.q_valid = valid_r[top];
        assign bus.usedw   = usedw_r;
    end

endmodule
